// File: rtl/queue_alu_pkg.sv
// Shared opcodes, response error codes and FSM states for the queue ALU core.
package queue_alu_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_DIV  = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
  localparam logic [2:0] ERR_DIVZERO   = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL   = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

endpackage

// File: rtl/queue_alu_core_if.sv
// Command/response bundle of the queue ALU core; master drives commands, slave is the core.
interface queue_alu_core_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_err;
  logic [CW-1:0]    q_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, q_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, q_count
  );

endinterface

// File: rtl/queue_alu_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after start.
module queue_alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = !diff[WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= CW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_q  <= {quo_q[WIDTH-2:0], fits};
      cnt_q  <= cnt_q - CW'(1);
      busy_q <= (cnt_q != CW'(1));
    end
  end

  // done marks the cycle whose closing edge commits the final quotient bit
  assign done      = busy_q && (cnt_q == CW'(1));
  assign busy      = busy_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/queue_alu_core.sv
// Queue ALU core: circular operand FIFO, single-cycle PUSH/POP/ADD/MUL/SUB, iterative DIV/REM.
// Define QALU_SIGNED_EN for two's-complement SUB/DIV/REM; the default build is unsigned.
module queue_alu_core
  import queue_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  queue_alu_core_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [PW-1:0] ptr_t;

  state_e           state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             head, tail, head_next, tail_next, ptr_b, ptr_c;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] op_a, op_b, alu_result, mem_wdata;
  logic             mem_we, accept;
  logic             rsp_valid, rsp_valid_next;
  logic [WIDTH-1:0] rsp_data, rsp_data_next;
  logic [2:0]       rsp_err, rsp_err_next;
  logic             rem_op, rem_op_next;
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quo, div_rem, div_result;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign ptr_b = ptr_inc(head);
  assign ptr_c = ptr_inc(ptr_b);
  assign op_a  = mem[head];
  assign op_b  = mem[ptr_b];

  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.cmd_ready = (state == IDLE) && !div_busy;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;
  assign bus.q_count   = count;

  always_comb begin
    alu_result = '0;
    case (bus.cmd_op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_MUL:  alu_result = op_a * op_b;
      default: alu_result = '0;
    endcase
  end

`ifdef QALU_SIGNED_EN
  logic quo_neg, rem_neg;

  // Divider sees magnitudes only; the signs are remembered here and applied in DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
    end else if (div_start) begin
      quo_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      rem_neg <= op_a[WIDTH-1];
    end
  end

  assign div_dividend = op_a[WIDTH-1] ? -op_a : op_a;
  assign div_divisor  = op_b[WIDTH-1] ? -op_b : op_b;
  assign div_result   = rem_op ? (rem_neg ? -div_rem : div_rem)
                               : (quo_neg ? -div_quo : div_quo);
`else
  assign div_dividend = op_a;
  assign div_divisor  = op_b;
  assign div_result   = rem_op ? div_rem : div_quo;
`endif

  queue_alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_next     = state;
    head_next      = head;
    tail_next      = tail;
    count_next     = count;
    mem_we         = 1'b0;
    mem_wdata      = '0;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data;
    rsp_err_next   = rsp_err;
    rem_op_next    = rem_op;
    div_start      = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = '0;
          rsp_err_next   = ERR_OK;
          case (bus.cmd_op)
            OP_PUSH: begin
              if (count < CW'(DEPTH)) begin
                mem_we        = 1'b1;
                mem_wdata     = bus.cmd_data;
                tail_next     = ptr_inc(tail);
                count_next    = count + CW'(1);
                rsp_data_next = bus.cmd_data;
              end else begin
                rsp_err_next = ERR_OVERFLOW;
              end
            end
            OP_POP: begin
              if (count != '0) begin
                rsp_data_next = op_a;
                head_next     = ptr_b;
                count_next    = count - CW'(1);
              end else begin
                rsp_err_next = ERR_UNDERFLOW;
              end
            end
            // A full queue has tail == head; op_a is read before that slot is overwritten
            OP_ADD, OP_SUB, OP_MUL: begin
              if (count >= CW'(2)) begin
                mem_we        = 1'b1;
                mem_wdata     = alu_result;
                head_next     = ptr_c;
                tail_next     = ptr_inc(tail);
                count_next    = count - CW'(1);
                rsp_data_next = alu_result;
              end else begin
                rsp_err_next = ERR_UNDERFLOW;
              end
            end
            OP_DIV, OP_REM: begin
              if (count >= CW'(2)) begin
                head_next  = ptr_c;
                count_next = count - CW'(2);
                if (op_b == '0) begin
                  rsp_err_next = ERR_DIVZERO;
                end else begin
                  rsp_valid_next = 1'b0;
                  div_start      = 1'b1;
                  rem_op_next    = (bus.cmd_op == OP_REM);
                  state_next     = DIV;
                end
              end else begin
                rsp_err_next = ERR_UNDERFLOW;
              end
            end
            default: rsp_err_next = ERR_ILLEGAL;
          endcase
        end
      end
      DIV: begin
        if (div_done) state_next = DONE;
      end
      DONE: begin
        mem_we         = 1'b1;
        mem_wdata      = div_result;
        tail_next      = ptr_inc(tail);
        count_next     = count + CW'(1);
        rsp_valid_next = 1'b1;
        rsp_data_next  = div_result;
        rsp_err_next   = ERR_OK;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
      rem_op    <= 1'b0;
    end else begin
      state     <= state_next;
      head      <= head_next;
      tail      <= tail_next;
      count     <= count_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
      rsp_err   <= rsp_err_next;
      rem_op    <= rem_op_next;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[tail] <= mem_wdata;
  end

endmodule

// File: tb/tb_queue_alu_core.sv
// Self-checking bench for queue_alu_core (WIDTH=8, DEPTH=4): directed table, reset-mid-division, random vs queue model.
// Expectations follow QALU_SIGNED_EN when the build defines it.
module tb_queue_alu_core;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic [2:0] exp_err;
    int         exp_lat;
    int         exp_count;
    string      name;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [7:0] model_q[$];
  vec_t vecs[$];

  queue_alu_core_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  queue_alu_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input int d, input int ed, input int ee,
                              input int el, input int ec, input string name);
    vec_t v;
    v.op = op; v.data = 8'(d); v.exp_data = 8'(ed); v.exp_err = 3'(ee);
    v.exp_lat = el; v.exp_count = ec; v.name = name;
    return v;
  endfunction

  // Issues one command and waits (bounded) for its response; lat counts edges after the accept edge
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data,
                               output logic [7:0] r_data, output logic [2:0] r_err,
                               output int lat, output int cnt, output logic ready_low);
    int guard = 0;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL ready_timeout: cmd_ready 0 after 50 cycles, want 1");
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 0;
    ready_low = 1'b1;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.cmd_ready) ready_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.rsp_valid) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL rsp_timeout: no rsp_valid within 40 cycles of op %0d", op);
    end
    r_data = bus.rsp_data;
    r_err  = bus.rsp_err;
    cnt    = int'(bus.q_count);
  endtask

  // Reference: spec rules on a plain SV queue with integer arithmetic
  task automatic model_exec(input logic [2:0] op, input logic [7:0] data,
                            output logic [7:0] e_data, output logic [2:0] e_err, output int e_lat);
    logic [7:0] a, b;
    int ia, ib, res;
    e_data = 8'd0;
    e_err  = 3'd0;
    e_lat  = 0;
    if (op == 3'd0) begin
      if (model_q.size() < DEPTH) begin
        model_q.push_back(data);
        e_data = data;
      end else e_err = 3'd2;
    end else if (op == 3'd1) begin
      if (model_q.size() >= 1) e_data = model_q.pop_front();
      else e_err = 3'd1;
    end else if (op == 3'd7) begin
      e_err = 3'd4;
    end else if (model_q.size() < 2) begin
      e_err = 3'd1;
    end else begin
      a = model_q.pop_front();
      b = model_q.pop_front();
      if ((op == 3'd5 || op == 3'd6) && b == 8'd0) begin
        e_err = 3'd3;
      end else begin
        ia = int'(a);
        ib = int'(b);
`ifdef QALU_SIGNED_EN
        if (op >= 3'd4) begin
          ia = int'($signed(a));
          ib = int'($signed(b));
        end
`endif
        case (op)
          3'd2:    res = ia + ib;
          3'd3:    res = ia * ib;
          3'd4:    res = ia - ib;
          3'd5:    res = ia / ib;
          default: res = ia % ib;
        endcase
        e_data = 8'(res & 255);
        model_q.push_back(e_data);
        if (op >= 3'd5) e_lat = WIDTH + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] g_data, e_data, r_dat;
    logic [2:0] g_err, e_err, op, r_err;
    logic       g_rdy, no_rsp;
    int         g_lat, g_cnt, e_lat, sel;

    n_cmp = 0;
    n_fail = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 8'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("reset_count", 32'(bus.q_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 32'(bus.cmd_ready), 32'd1);

    vecs.push_back(mk(3'd0, 3, 3, 0, 0, 1, "push3"));
    vecs.push_back(mk(3'd0, 5, 5, 0, 0, 2, "push5"));
    vecs.push_back(mk(3'd2, 0, 8, 0, 0, 1, "add"));
    vecs.push_back(mk(3'd1, 0, 8, 0, 0, 0, "pop_sum"));
    vecs.push_back(mk(3'd1, 0, 0, 1, 0, 0, "pop_empty"));
    vecs.push_back(mk(3'd0, 200, 200, 0, 0, 1, "push200"));
    vecs.push_back(mk(3'd0, 100, 100, 0, 0, 2, "push100"));
    vecs.push_back(mk(3'd3, 0, 8'h20, 0, 0, 1, "mul"));
    vecs.push_back(mk(3'd1, 0, 8'h20, 0, 0, 0, "pop_mul"));
    vecs.push_back(mk(3'd0, 3, 3, 0, 0, 1, "push3b"));
    vecs.push_back(mk(3'd0, 10, 10, 0, 0, 2, "push10"));
    vecs.push_back(mk(3'd4, 0, 8'hF9, 0, 0, 1, "sub"));
    vecs.push_back(mk(3'd1, 0, 8'hF9, 0, 0, 0, "pop_sub"));
    vecs.push_back(mk(3'd0, 100, 100, 0, 0, 1, "push100b"));
    vecs.push_back(mk(3'd0, 7, 7, 0, 0, 2, "push7"));
    vecs.push_back(mk(3'd5, 0, 14, 0, WIDTH + 1, 1, "div"));
    vecs.push_back(mk(3'd1, 0, 14, 0, 0, 0, "pop_div"));
    vecs.push_back(mk(3'd0, 100, 100, 0, 0, 1, "push100c"));
    vecs.push_back(mk(3'd0, 7, 7, 0, 0, 2, "push7b"));
    vecs.push_back(mk(3'd6, 0, 2, 0, WIDTH + 1, 1, "rem"));
    vecs.push_back(mk(3'd1, 0, 2, 0, 0, 0, "pop_rem"));
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(3'd0, i, i, 0, 0, i, $sformatf("fill%0d", i)));
    vecs.push_back(mk(3'd0, 5, 0, 2, 0, 4, "push_full"));
    vecs.push_back(mk(3'd1, 0, 1, 0, 0, 3, "pop1"));
    vecs.push_back(mk(3'd1, 0, 2, 0, 0, 2, "pop2"));
    vecs.push_back(mk(3'd0, 6, 6, 0, 0, 3, "push6_wrap"));
    vecs.push_back(mk(3'd0, 7, 7, 0, 0, 4, "push7_wrap"));
    vecs.push_back(mk(3'd1, 0, 3, 0, 0, 3, "wpop3"));
    vecs.push_back(mk(3'd1, 0, 4, 0, 0, 2, "wpop4"));
    vecs.push_back(mk(3'd1, 0, 6, 0, 0, 1, "wpop6"));
    vecs.push_back(mk(3'd1, 0, 7, 0, 0, 0, "wpop7"));
    vecs.push_back(mk(3'd0, 9, 9, 0, 0, 1, "push9"));
    vecs.push_back(mk(3'd0, 0, 0, 0, 0, 2, "push0"));
    vecs.push_back(mk(3'd5, 0, 0, 3, 0, 0, "divzero"));
    vecs.push_back(mk(3'd0, 1, 1, 0, 0, 1, "push1"));
    vecs.push_back(mk(3'd2, 0, 0, 1, 0, 1, "add_under"));
    vecs.push_back(mk(3'd1, 0, 1, 0, 0, 0, "pop_one"));
    vecs.push_back(mk(3'd7, 0, 0, 4, 0, 0, "illegal"));
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(3'd0, 10 * i, 10 * i, 0, 0, i, $sformatf("full%0d", i)));
    vecs.push_back(mk(3'd2, 0, 30, 0, 0, 3, "add_full"));
    vecs.push_back(mk(3'd1, 0, 30, 0, 0, 2, "fpop30"));
    vecs.push_back(mk(3'd1, 0, 40, 0, 0, 1, "fpop40"));
    vecs.push_back(mk(3'd1, 0, 30, 0, 0, 0, "fpop_sum"));
`ifdef QALU_SIGNED_EN
    vecs.push_back(mk(3'd0, 8'h9C, 8'h9C, 0, 0, 1, "push_m100"));
    vecs.push_back(mk(3'd0, 7, 7, 0, 0, 2, "push7s"));
    vecs.push_back(mk(3'd5, 0, 8'hF2, 0, WIDTH + 1, 1, "sdiv"));
    vecs.push_back(mk(3'd1, 0, 8'hF2, 0, 0, 0, "pop_sdiv"));
    vecs.push_back(mk(3'd0, 8'h9C, 8'h9C, 0, 0, 1, "push_m100b"));
    vecs.push_back(mk(3'd0, 7, 7, 0, 0, 2, "push7t"));
    vecs.push_back(mk(3'd6, 0, 8'hFE, 0, WIDTH + 1, 1, "srem"));
    vecs.push_back(mk(3'd1, 0, 8'hFE, 0, 0, 0, "pop_srem"));
    vecs.push_back(mk(3'd0, 8'h80, 8'h80, 0, 0, 1, "push_min"));
    vecs.push_back(mk(3'd0, 8'hFF, 8'hFF, 0, 0, 2, "push_m1"));
    vecs.push_back(mk(3'd5, 0, 8'h80, 0, WIDTH + 1, 1, "sdiv_min"));
    vecs.push_back(mk(3'd1, 0, 8'h80, 0, 0, 0, "pop_min"));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].data, g_data, g_err, g_lat, g_cnt, g_rdy);
      checkOutput({vecs[i].name, "_data"}, 32'(g_data), 32'(vecs[i].exp_data));
      checkOutput({vecs[i].name, "_err"}, 32'(g_err), 32'(vecs[i].exp_err));
      checkOutput({vecs[i].name, "_lat"}, 32'(g_lat), 32'(vecs[i].exp_lat));
      checkOutput({vecs[i].name, "_count"}, 32'(g_cnt), 32'(vecs[i].exp_count));
      if (vecs[i].exp_lat > 0) checkOutput({vecs[i].name, "_ready_low"}, 32'(g_rdy), 32'd1);
    end

    // Reset three cycles into a division: the pending result must never appear
    applyStimulus(3'd0, 8'd100, r_dat, r_err, g_lat, g_cnt, g_rdy);
    applyStimulus(3'd0, 8'd7, r_dat, r_err, g_lat, g_cnt, g_rdy);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd5;
    bus.cmd_data  = 8'd0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    no_rsp = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) no_rsp = 1'b0;
    end
    checkOutput("mid_div_ready_low", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_div_rst_count", 32'(bus.q_count), 32'd0);
    checkOutput("mid_div_rst_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_div_ready_after", 32'(bus.cmd_ready), 32'd1);
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) no_rsp = 1'b0;
    end
    checkOutput("mid_div_no_rsp", 32'(no_rsp), 32'd1);
    applyStimulus(3'd0, 8'd42, g_data, g_err, g_lat, g_cnt, g_rdy);
    checkOutput("post_rst_push_data", 32'(g_data), 32'd42);
    checkOutput("post_rst_push_count", 32'(g_cnt), 32'd1);
    applyStimulus(3'd1, 8'd0, g_data, g_err, g_lat, g_cnt, g_rdy);
    checkOutput("post_rst_pop_data", 32'(g_data), 32'd42);
    checkOutput("post_rst_pop_err", 32'(g_err), 32'd0);
    checkOutput("post_rst_pop_count", 32'(g_cnt), 32'd0);

    do_reset();
    model_q.delete();
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 11));
      if (sel <= 3) op = 3'd0;
      else if (sel == 10) op = 3'd5;
      else if (sel == 11) op = 3'd7;
      else op = 3'(sel - 3);
      if ($urandom_range(0, 3) == 0) g_data = 8'($urandom_range(0, 3));
      else g_data = 8'($urandom_range(0, 255));
      model_exec(op, g_data, e_data, e_err, e_lat);
      applyStimulus(op, g_data, r_dat, r_err, g_lat, g_cnt, g_rdy);
      checkOutput($sformatf("rnd%0d_op%0d_data", i, op), 32'(r_dat), 32'(e_data));
      checkOutput($sformatf("rnd%0d_op%0d_err", i, op), 32'(r_err), 32'(e_err));
      checkOutput($sformatf("rnd%0d_op%0d_lat", i, op), 32'(g_lat), 32'(e_lat));
      checkOutput($sformatf("rnd%0d_op%0d_count", i, op), 32'(g_cnt), 32'(model_q.size()));
      if (e_lat > 0) checkOutput($sformatf("rnd%0d_ready_low", i), 32'(g_rdy), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
